uart_tx_top: RTL and testbench

UART_TX_TOP -- requirements
Module: uart_tx_top

---
 rtl/uart_tx_pkg.sv | 27 ++
 rtl/uart_baud_tick.sv | 30 +++
 rtl/uart_tx_top.sv | 108 ++++++++++
 tb/tb_uart_tx_top.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the UART transmitter.
package uart_tx_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [1:0] {
        PAR_NONE  = 2'b00,
        PAR_EVEN  = 2'b01,
        PAR_ODD   = 2'b10,
        PAR_NONE2 = 2'b11
    } parity_mode_e;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

    // Even parity is the plain XOR of the byte; odd parity is its inverse.
    function automatic logic calc_parity(input logic [DATA_BITS-1:0] data,
                                         input parity_mode_e mode);
        return (^data) ^ (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period tick generator: pulses o_tick on the last cycle of each bit period.
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_srst,
    output logic o_tick
);

    localparam logic [15:0] LAST_CNT = 16'(CLKS_PER_BIT - 1);

    logic [15:0] r_cnt;

    // Period counter, held at zero while idle so each frame starts a fresh period.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= 16'd0;
        end else if (i_srst) begin
            r_cnt <= 16'd0;
        end else if (r_cnt == LAST_CNT) begin
            r_cnt <= 16'd0;
        end else begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

    assign o_tick = (r_cnt == LAST_CNT) && !i_srst;

endmodule

// File: rtl/uart_tx_top.sv
// UART transmitter: start bit, 8 data bits LSB first, optional parity, one stop bit.
module uart_tx_top
    import uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       VALID,
    input  logic [7:0] DATA_IN,
    input  logic [1:0] PARITY_MODE,
    output logic       TXD
);

    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    tx_state_e              r_state;
    logic [2:0]             r_bit_idx;
    logic [DATA_BITS-1:0]   r_data;
    parity_mode_e           r_mode;
    logic                   r_txd;

    logic w_tick;
    logic w_parity;
    logic w_has_parity;
    logic w_baud_srst;

    assign w_baud_srst  = (r_state == IDLE);
    assign w_parity     = calc_parity(r_data, r_mode);
    assign w_has_parity = (r_mode == PAR_EVEN) || (r_mode == PAR_ODD);
    assign TXD          = r_txd;

    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_tick (
        .i_clk  (CLK),
        .i_rst_n(RST_N),
        .i_srst (w_baud_srst),
        .o_tick (w_tick)
    );

    // Frame sequencer; TXD is registered so the line changes right after the edge.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state   <= IDLE;
            r_bit_idx <= 3'd0;
            r_data    <= 8'h00;
            r_mode    <= PAR_NONE;
            r_txd     <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (VALID) begin
                        r_state   <= START;
                        r_data    <= DATA_IN;
                        r_mode    <= parity_mode_e'(PARITY_MODE);
                        r_bit_idx <= 3'd0;
                        r_txd     <= 1'b0;
                    end else begin
                        r_txd     <= 1'b1;
                    end
                end
                START: begin
                    if (w_tick) begin
                        r_state   <= DATA;
                        r_bit_idx <= 3'd0;
                        r_txd     <= r_data[0];
                    end
                end
                DATA: begin
                    if (w_tick) begin
                        if (r_bit_idx == LAST_BIT) begin
                            if (w_has_parity) begin
                                r_state <= PARITY;
                                r_txd   <= w_parity;
                            end else begin
                                r_state <= STOP;
                                r_txd   <= 1'b1;
                            end
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                            r_txd     <= r_data[r_bit_idx + 3'd1];
                        end
                    end
                end
                PARITY: begin
                    if (w_tick) begin
                        r_state <= STOP;
                        r_txd   <= 1'b1;
                    end
                end
                STOP: begin
                    if (w_tick) begin
                        r_state   <= IDLE;
                        r_bit_idx <= 3'd0;
                        r_txd     <= 1'b1;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_bit_idx <= 3'd0;
                    r_txd     <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_top.sv
// Directed bench for uart_tx_top with CLKS_PER_BIT=1; expected frames are written in line order.
module tb_uart_tx_top;

    logic       CLK;
    logic       RST_N;
    logic       VALID;
    logic [7:0] DATA_IN;
    logic [1:0] PARITY_MODE;
    logic       TXD;

    int n_tests;
    int n_fail;

    uart_tx_top #(.CLKS_PER_BIT(1)) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .VALID      (VALID),
        .DATA_IN    (DATA_IN),
        .PARITY_MODE(PARITY_MODE),
        .TXD        (TXD)
    );

    initial begin
        CLK = 1'b0;
        forever #10 CLK = ~CLK;
    end

    // Pulses VALID for one edge and records n line samples, first sample in the MSB.
    task automatic frame(input logic [7:0] d, input logic [1:0] m, input int n,
                         output logic [15:0] v);
        v = 16'd0;
        DATA_IN = d;
        PARITY_MODE = m;
        VALID = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            v = {v[14:0], TXD};
            if (i == 0) VALID = 1'b0;
        end
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        VALID = 1'b1;
        DATA_IN = 8'hFF;
        PARITY_MODE = 2'b01;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            n_tests++;
            if (TXD !== 1'b1) begin
                n_fail++;
                $display("FAIL reset_hold cycle %0d: TXD=%b expected 1", i, TXD);
            end
        end
        VALID = 1'b0;
        RST_N = 1'b1;
    endtask

    task automatic test_idle();
        logic [15:0] v;
        v = 16'd0;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            v = {v[14:0], TXD};
        end
        n_tests++;
        if (v[9:0] !== 10'b11_1111_1111) begin
            n_fail++;
            $display("FAIL idle: TXD seq=%b expected %b", v[9:0], 10'b11_1111_1111);
        end
    endtask

    task automatic test_no_parity();
        logic [15:0] v;
        frame(8'hA3, 2'b00, 11, v);
        n_tests++;
        if (v[10:0] !== 11'b0_11000101_1_1) begin
            n_fail++;
            $display("FAIL no_parity_A3: TXD seq=%b expected %b", v[10:0], 11'b0_11000101_1_1);
        end
    endtask

    task automatic test_mode11();
        logic [15:0] v;
        frame(8'hFF, 2'b11, 11, v);
        n_tests++;
        if (v[10:0] !== 11'b0_11111111_1_1) begin
            n_fail++;
            $display("FAIL mode11_FF: TXD seq=%b expected %b", v[10:0], 11'b0_11111111_1_1);
        end
    endtask

    task automatic test_even_parity();
        logic [15:0] v;
        frame(8'hF4, 2'b01, 12, v);
        n_tests++;
        if (v[11:0] !== 12'b0_00101111_1_1_1) begin
            n_fail++;
            $display("FAIL even_F4: TXD seq=%b expected %b", v[11:0], 12'b0_00101111_1_1_1);
        end
    endtask

    task automatic test_odd_parity();
        logic [15:0] v;
        frame(8'h4F, 2'b10, 12, v);
        n_tests++;
        if (v[11:0] !== 12'b0_11110010_0_1_1) begin
            n_fail++;
            $display("FAIL odd_4F: TXD seq=%b expected %b", v[11:0], 12'b0_11110010_0_1_1);
        end
    endtask

    task automatic test_busy_drop();
        logic [15:0] v;
        v = 16'd0;
        DATA_IN = 8'hA3;
        PARITY_MODE = 2'b00;
        VALID = 1'b1;
        for (int i = 0; i < 14; i++) begin
            @(negedge CLK);
            v = {v[14:0], TXD};
            if (i == 0) VALID = 1'b0;
            if (i == 2) begin
                VALID = 1'b1;
                DATA_IN = 8'h55;
                PARITY_MODE = 2'b01;
            end
            if (i == 3) VALID = 1'b0;
        end
        PARITY_MODE = 2'b00;
        n_tests++;
        if (v[13:0] !== 14'b0_11000101_1_1111) begin
            n_fail++;
            $display("FAIL busy_drop: TXD seq=%b expected %b", v[13:0], 14'b0_11000101_1_1111);
        end
    endtask

    task automatic test_mid_frame_reset();
        logic [15:0] v;
        v = 16'd0;
        DATA_IN = 8'h00;
        PARITY_MODE = 2'b00;
        VALID = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            v = {v[14:0], TXD};
            if (i == 0) VALID = 1'b0;
        end
        n_tests++;
        if (v[3:0] !== 4'b0000) begin
            n_fail++;
            $display("FAIL pre_reset_frame: TXD seq=%b expected %b", v[3:0], 4'b0000);
        end
        #2 RST_N = 1'b0;
        #1;
        n_tests++;
        if (TXD !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_async: TXD=%b expected 1", TXD);
        end
        VALID = 1'b1;
        DATA_IN = 8'hFF;
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK);
            n_tests++;
            if (TXD !== 1'b1) begin
                n_fail++;
                $display("FAIL reset_mid_hold cycle %0d: TXD=%b expected 1", i, TXD);
            end
        end
        RST_N = 1'b1;
        frame(8'h3C, 2'b10, 12, v);
        n_tests++;
        if (v[11:0] !== 12'b0_00111100_1_1_1) begin
            n_fail++;
            $display("FAIL post_reset_3C: TXD seq=%b expected %b", v[11:0], 12'b0_00111100_1_1_1);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] v;
        logic        found;
        v = 16'd0;
        DATA_IN = 8'h96;
        PARITY_MODE = 2'b00;
        VALID = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            v = {v[14:0], TXD};
            if (i == 0) DATA_IN = 8'h5A;
        end
        n_tests++;
        if (v[9:0] !== 10'b0_01101001_1) begin
            n_fail++;
            $display("FAIL b2b_first_96: TXD seq=%b expected %b", v[9:0], 10'b0_01101001_1);
        end
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (!found) begin
                @(negedge CLK);
                if (TXD === 1'b0) found = 1'b1;
            end
        end
        n_tests++;
        if (found !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_second_start: found=%b expected 1", found);
        end else begin
            v = 16'd0;
            for (int i = 0; i < 9; i++) begin
                @(negedge CLK);
                v = {v[14:0], TXD};
            end
            n_tests++;
            if (v[8:0] !== 9'b01011010_1) begin
                n_fail++;
                $display("FAIL b2b_second_5A: TXD seq=%b expected %b", v[8:0], 9'b01011010_1);
            end
        end
        VALID = 1'b0;
        repeat (3) @(negedge CLK);
    endtask

    initial begin
        n_tests = 0;
        n_fail = 0;
        RST_N = 1'b0;
        VALID = 1'b0;
        DATA_IN = 8'h00;
        PARITY_MODE = 2'b00;
        test_reset();
        test_idle();
        test_no_parity();
        test_mode11();
        test_even_parity();
        test_odd_parity();
        test_busy_drop();
        test_mid_frame_reset();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
